// File: rtl/posit_pkg.sv
// rtl/posit_pkg.sv - shared posit constants and decoded-operand record
package posit_pkg;

  localparam int N  = 32;
  localparam int ES = 2;
  localparam int RS = $clog2(N);

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 inf;
    logic signed [RS:0]   regime;
    logic [ES-1:0]        exp;
    logic signed [ES+RS:0] le;
    logic [N-1:0]         mant;
  } posit_dec_t;

endpackage

// File: rtl/posit_regime_lzd.sv
// rtl/posit_regime_lzd.sv - length of the leading run of identical bits (the regime)
module posit_regime_lzd
  import posit_pkg::*;
(
  input  logic [N-2:0]  bits,
  output logic [RS-1:0] run,
  output logic          r0
);

  logic done;

  always_comb begin
    r0   = bits[N-2];
    run  = '0;
    done = 1'b0;
    for (int i = N - 2; i >= 0; i--) begin
      if (!done && bits[i] == r0) run = run + RS'(1);
      else done = 1'b1;
    end
  end

endmodule

// File: rtl/posit_decode_pipe.sv
// rtl/posit_decode_pipe.sv - elastic two-stage posit unpacker feeding the add/sub core
module posit_decode_pipe
  import posit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_posit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic                  out_zero,
  output logic                  out_inf,
  output logic signed [RS:0]    out_regime,
  output logic [ES-1:0]         out_exp,
  output logic signed [ES+RS:0] out_le,
  output logic [N-1:0]          out_mant
);

  logic         s1_valid, s1_ready, s2_valid, s2_ready;
  logic         s1_sign, s1_zero, s1_inf;
  logic [N-2:0] s1_abs;
  posit_dec_t   s2_q, s2_d;
  logic [RS-1:0] run;
  logic         r0;
  logic [RS:0]  run_x, k;
  logic [N-2:0] rem;

  assign s2_ready = !s2_valid || out_ready;
  assign s1_ready = !s1_valid || s2_ready;
  assign in_ready = s1_ready;

  // Only the low N-1 bits of |x| are needed; they depend only on the low bits of x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_zero  <= 1'b0;
      s1_inf   <= 1'b0;
      s1_abs   <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_posit[N-1];
        s1_abs  <= in_posit[N-1] ? ((N-1)'(0) - in_posit[N-2:0]) : in_posit[N-2:0];
        s1_zero <= (in_posit == '0);
        s1_inf  <= (in_posit == {1'b1, {(N-1){1'b0}}});
      end
    end
  end

  posit_regime_lzd u_lzd (
    .bits (s1_abs),
    .run  (run),
    .r0   (r0)
  );

  // Dropping the regime and its terminator leaves exp then fraction left-aligned.
  always_comb begin
    run_x       = {1'b0, run};
    k           = r0 ? (run_x - (RS+1)'(1)) : ((RS+1)'(0) - run_x);
    rem         = s1_abs << (run_x + (RS+1)'(1));
    s2_d.sign   = s1_sign;
    s2_d.zero   = s1_zero;
    s2_d.inf    = s1_inf;
    s2_d.regime = k;
    s2_d.exp    = rem[N-2 -: ES];
    s2_d.le     = {k, rem[N-2 -: ES]};
    s2_d.mant   = {1'b1, rem[N-2-ES:0], {ES{1'b0}}};
    if (s1_zero || s1_inf) begin
      s2_d.regime = '0;
      s2_d.exp    = '0;
      s2_d.le     = '0;
      s2_d.mant   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) s2_q <= s2_d;
    end
  end

  assign out_valid  = s2_valid;
  assign out_sign   = s2_q.sign;
  assign out_zero   = s2_q.zero;
  assign out_inf    = s2_q.inf;
  assign out_regime = s2_q.regime;
  assign out_exp    = s2_q.exp;
  assign out_le     = s2_q.le;
  assign out_mant   = s2_q.mant;

endmodule
